// File: rtl/playback_engine.sv
// ---------------------------------------------------------------------------
// playback_engine
//
// Read side of the audio sample buffer. It drives the BRAM read port and
// streams a stored recording to the output stage, one sample per audio
// sample tick. Recordings play once or loop.
//
// Optional feature macro: PLAYBACK_ECHO_EN
//   When defined, every fetch issues a second read ECHO_DELAY samples back.
//   Half of that older sample is mixed into the current one, with saturation.
//   Each output then arrives one cycle later than in the plain build.
//
// Ports
//   clk_in           in   system clock
//   rst_n_in         in   asynchronous active-low reset
//   sample_tick_in   in   1-cycle strobe at the audio sample rate
//   start_in         in   1-cycle start request (ignored while busy)
//   stop_in          in   1-cycle abort request (wins over start_in)
//   loop_in          in   sampled at end of recording, 1 = wrap to address 0
//   length_in        in   recording length in samples, latched on start
//   r_addr_out       out  BRAM read address
//   r_data_in        in   signed BRAM read data, RAM_LATENCY cycles after address
//   audio_out        out  signed output sample, held between updates
//   audio_valid_out  out  1-cycle pulse when audio_out updates
//   busy_out         out  high whenever the engine is not idle
//   done_out         out  1-cycle pulse on normal, non-looped completion
//   missed_tick_out  out  sticky flag: a tick arrived while a fetch was running
// ---------------------------------------------------------------------------
module playback_engine #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int RAM_LATENCY = 2,
    parameter int ECHO_DELAY  = 3000
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              sample_tick_in,
    input  logic              start_in,
    input  logic              stop_in,
    input  logic              loop_in,
    input  logic [ADDR_W-1:0] length_in,
    output logic [ADDR_W-1:0] r_addr_out,
    input  logic [DATA_W-1:0] r_data_in,
    output logic [DATA_W-1:0] audio_out,
    output logic              audio_valid_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              missed_tick_out
);

    // A tap distance of zero, or one that does not fit in the address, cannot work.
    if (ECHO_DELAY < 1 || ECHO_DELAY > (2 ** ADDR_W) - 1) begin : g_bad_echo_delay
        $error("playback_engine: ECHO_DELAY must lie in 1 .. 2**ADDR_W-1");
    end

`ifdef PLAYBACK_ECHO_EN
    // The echo read trails the primary read by one cycle, so FETCH lasts one cycle longer.
    localparam int FETCH_CYCLES = RAM_LATENCY + 1;
`else
    localparam int FETCH_CYCLES = RAM_LATENCY;
`endif
    localparam int                CNT_W      = $clog2(FETCH_CYCLES + 2);
    localparam logic [CNT_W-1:0]  FETCH_LAST = CNT_W'(FETCH_CYCLES);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TICK,
        FETCH,
        EMIT
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] len;
    logic [CNT_W-1:0]  fetch_cnt;
    logic              fetch_done;
    logic              at_end;
    logic              start_ok;

    // The fetch counter starts at 0 on the cycle after the address is issued.
    // When it reaches FETCH_LAST, the sample on r_data_in is the one to emit.
    always_comb begin
        fetch_done = (fetch_cnt == FETCH_LAST);
        at_end     = (ptr == len - ADDR_ONE);
        start_ok   = start_in && !stop_in;
        busy_out   = (state != IDLE);
    end

`ifdef PLAYBACK_ECHO_EN
    localparam logic [ADDR_W-1:0] ECHO_DIST    = ADDR_W'(ECHO_DELAY);
    localparam logic [CNT_W-1:0]  PRIMARY_LAST = CNT_W'(RAM_LATENCY);

    logic [DATA_W-1:0]        cur_sample;
    logic                     echo_rd;
    logic signed [DATA_W-1:0] echo_sample;
    logic signed [DATA_W-1:0] echo_half;
    logic signed [DATA_W:0]   mix_sum;
    logic [DATA_W-1:0]        mix_out;

    // Mix the current sample with half of the echo sample.
    // The sum is one bit wider than a sample. If its top two bits disagree,
    // the result overflowed and is clamped to the nearest signed limit.
    always_comb begin
        echo_sample = echo_rd ? $signed(r_data_in) : '0;
        echo_half   = echo_sample >>> 1;
        mix_sum     = {cur_sample[DATA_W-1], cur_sample} + {echo_half[DATA_W-1], echo_half};
        if (mix_sum[DATA_W] != mix_sum[DATA_W-1]) begin
            mix_out = mix_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            mix_out = mix_sum[DATA_W-1:0];
        end
    end
`endif

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A zero-length start stays in IDLE and only pulses done_out.
    // stop_in overrides every other transition.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_ok && length_in != '0) begin
                    next_state = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (sample_tick_in) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                if (fetch_done) begin
                    next_state = EMIT;
                end
            end
            EMIT: begin
                if (at_end && !loop_in) begin
                    next_state = IDLE;
                end else begin
                    next_state = WAIT_TICK;
                end
            end
            default: next_state = IDLE;
        endcase
        if (stop_in) begin
            next_state = IDLE;
        end
    end

    // Datapath: pointer, latched length, read address, and registered outputs.
    // audio_out and audio_valid_out update on the same edge that leaves FETCH,
    // so the valid pulse lines up with the EMIT cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ptr             <= '0;
            len             <= '0;
            fetch_cnt       <= '0;
            r_addr_out      <= '0;
            audio_out       <= '0;
            audio_valid_out <= 1'b0;
            done_out        <= 1'b0;
            missed_tick_out <= 1'b0;
`ifdef PLAYBACK_ECHO_EN
            cur_sample      <= '0;
            echo_rd         <= 1'b0;
`endif
        end else begin
            audio_valid_out <= 1'b0;
            done_out        <= 1'b0;
            if (stop_in) begin
                audio_out <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_in) begin
                            len             <= length_in;
                            ptr             <= '0;
                            missed_tick_out <= 1'b0;
                            if (length_in == '0) begin
                                done_out <= 1'b1;
                            end
                        end
                    end
                    WAIT_TICK: begin
                        if (sample_tick_in) begin
                            r_addr_out <= ptr;
                            fetch_cnt  <= '0;
                        end
                    end
                    FETCH: begin
                        if (sample_tick_in) begin
                            missed_tick_out <= 1'b1;
                        end
                        fetch_cnt <= fetch_cnt + 1'b1;
`ifdef PLAYBACK_ECHO_EN
                        // The older sample only exists once ptr has moved past the tap distance.
                        if (fetch_cnt == '0) begin
                            echo_rd <= (ptr >= ECHO_DIST);
                            if (ptr >= ECHO_DIST) begin
                                r_addr_out <= ptr - ECHO_DIST;
                            end
                        end
                        if (fetch_cnt == PRIMARY_LAST) begin
                            cur_sample <= r_data_in;
                        end
                        if (fetch_done) begin
                            audio_out       <= mix_out;
                            audio_valid_out <= 1'b1;
                        end
`else
                        if (fetch_done) begin
                            audio_out       <= r_data_in;
                            audio_valid_out <= 1'b1;
                        end
`endif
                    end
                    EMIT: begin
                        if (at_end) begin
                            if (loop_in) begin
                                ptr <= '0;
                            end else begin
                                done_out <= 1'b1;
                            end
                        end else begin
                            ptr <= ptr + ADDR_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_playback_engine.sv
// ---------------------------------------------------------------------------
// tb_playback_engine
//
// Scoreboard bench for playback_engine. A BRAM model drives the read port.
// A recording-level reference model predicts each output sample, the cycle it
// should appear in, and done pulses, and pushes them into queues. A separate
// monitor pops and compares whenever the DUT presents audio_valid_out or done_out.
// Honours PLAYBACK_ECHO_EN: expected latency and mixing follow the macro.
// ---------------------------------------------------------------------------
module tb_playback_engine;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 8;
    localparam int RAM_LATENCY = 2;
    localparam int ECHO_DELAY  = 3000;
`ifdef PLAYBACK_ECHO_EN
    localparam int LAT  = RAM_LATENCY + 3;
    localparam bit ECHO = 1'b1;
`else
    localparam int LAT  = RAM_LATENCY + 2;
    localparam bit ECHO = 1'b0;
`endif

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b1;
    logic              tick    = 1'b0;
    logic              start   = 1'b0;
    logic              stop    = 1'b0;
    logic              loop_en = 1'b0;
    logic [ADDR_W-1:0] length  = '0;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] audio;
    logic              audio_valid;
    logic              busy;
    logic              done;
    logic              missed;

    logic [DATA_W-1:0] mem [0:4095];
    logic [DATA_W-1:0] stage1;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];

    // Reference model state: whole-recording view of the playback.
    bit m_active = 1'b0;
    bit m_missed = 1'b0;
    int m_pos    = 0;
    int m_len    = 0;

    playback_engine #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LATENCY(RAM_LATENCY), .ECHO_DELAY(ECHO_DELAY)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .sample_tick_in(tick),
        .start_in(start),
        .stop_in(stop),
        .loop_in(loop_en),
        .length_in(length),
        .r_addr_out(r_addr),
        .r_data_in(r_data),
        .audio_out(audio),
        .audio_valid_out(audio_valid),
        .busy_out(busy),
        .done_out(done),
        .missed_tick_out(missed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Read-first BRAM with an output register: two cycles from address to data.
    always @(posedge clk) begin
        stage1 <= mem[r_addr[11:0]];
        r_data <= stage1;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int ramVal(input int a);
        return int'($signed(mem[a]));
    endfunction

    // Expected output sample for recording position pos.
    function automatic int expSample(input int pos);
        int v;
        v = ramVal(pos);
        if (ECHO && pos >= ECHO_DELAY) begin
            v = v + (ramVal(pos - ECHO_DELAY) >>> 1);
            if (v > 127) v = 127;
            if (v < -128) v = -128;
        end
        return v;
    endfunction

    // Monitor: compares every DUT output event against the front of its queue.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   dc;
        if (rst_n === 1'b1) begin
            if (audio_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("audio_valid_unexpected", int'(audio_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("audio_out", int'($signed(audio)), e.data);
                    checkOutput("audio_valid_cycle", cyc, e.cyc);
                end
            end
            if (done === 1'b1) begin
                if (done_q.size() == 0) begin
                    checkOutput("done_unexpected", int'(done), 0);
                end else begin
                    dc = done_q.pop_front();
                    checkOutput("done_cycle", cyc, dc);
                end
            end
        end
    end

    // Drive one cycle of inputs starting just after a rising edge.
    task automatic applyStimulus(input logic t, input logic s, input logic p);
        tick  = t;
        start = s;
        stop  = p;
        @(posedge clk);
        #1;
        tick  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doStart(input int len, input bit lp);
        int c;
        c       = cyc;
        length  = ADDR_W'(len);
        loop_en = lp;
        if (!m_active) begin
            m_len    = len;
            m_missed = 1'b0;
            if (len == 0) begin
                done_q.push_back(c + 1);
            end else begin
                m_active = 1'b1;
                m_pos    = 0;
            end
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        length = ADDR_W'($urandom);
        checkOutput("busy_after_start", int'(busy), int'(m_active));
        checkOutput("missed_after_start", int'(missed), int'(m_missed));
    endtask

    task automatic doTick(input int gap);
        int   c;
        int   addr;
        bit   act;
        exp_t e;
        c    = cyc;
        act  = m_active;
        addr = m_pos;
        if (m_active) begin
            e.data = expSample(m_pos);
            e.cyc  = c + LAT;
            exp_q.push_back(e);
            if (m_pos == m_len - 1) begin
                if (loop_en) begin
                    m_pos = 0;
                end else begin
                    done_q.push_back(c + LAT + 1);
                    m_active = 1'b0;
                end
            end else begin
                m_pos++;
            end
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        if (act) checkOutput("r_addr_after_tick", int'(r_addr), addr);
        idle(gap - 1);
    endtask

    task automatic doStop();
        m_active = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("busy_after_stop", int'(busy), 0);
        checkOutput("audio_after_stop", int'($signed(audio)), 0);
        checkOutput("missed_held_after_stop", int'(missed), int'(m_missed));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = DATA_W'($urandom);

        // Reset state
        #2 rst_n = 1'b0;
        idle(3);
        checkOutput("reset_r_addr", int'(r_addr), 0);
        checkOutput("reset_audio", int'(audio), 0);
        checkOutput("reset_valid", int'(audio_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_missed", int'(missed), 0);
        rst_n = 1'b1;
        idle(2);

        // One-shot: RAM[i]=i, four samples, two spare ticks produce nothing
        for (int i = 0; i < 8; i++) mem[i] = DATA_W'(i);
        doStart(4, 1'b0);
        repeat (6) doTick(20);
        checkOutput("busy_after_oneshot", int'(busy), 0);

        // Loop of three over seven ticks, then abort
        doStart(3, 1'b1);
        repeat (7) doTick(8);
        checkOutput("busy_in_loop", int'(busy), 1);
        doStop();

        // Stop after the second sample; later ticks are ignored
        doStart(4, 1'b0);
        repeat (2) doTick(8);
        doStop();
        repeat (2) doTick(8);

        // Start and stop together stay idle
        length = ADDR_W'(5);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("busy_start_stop", int'(busy), 0);
        idle(3);
        checkOutput("busy_start_stop_later", int'(busy), 0);

        // Zero length: done one cycle after start, never busy
        doStart(0, 1'b0);
        idle(3);
        checkOutput("busy_len0", int'(busy), 0);

        // Tick during FETCH sets the sticky flag until the next start
        doStart(4, 1'b0);
        doTick(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        m_missed = 1'b1;
        checkOutput("missed_set", int'(missed), 1);
        idle(6);
        repeat (3) doTick(8);
        checkOutput("missed_sticky", int'(missed), int'(m_missed));
        doStart(2, 1'b0);
        repeat (2) doTick(8);

        // Start while busy is ignored; the latched length is kept
        doStart(5, 1'b0);
        doTick(8);
        doStart(2, 1'b0);
        repeat (4) doTick(8);
        checkOutput("busy_after_ignored_start", int'(busy), 0);

        // Asynchronous reset in the middle of a fetch
        doStart(4, 1'b0);
        doTick(1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_r_addr", int'(r_addr), 0);
        checkOutput("midreset_audio", int'(audio), 0);
        checkOutput("midreset_valid", int'(audio_valid), 0);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_done", int'(done), 0);
        checkOutput("midreset_missed", int'(missed), 0);
        exp_q.delete();
        done_q.delete();
        m_active = 1'b0;
        m_missed = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Randomized runs
        for (int run = 0; run < 12; run++) begin
            int len;
            int nt;
            bit lp;
            len = $urandom_range(0, 6);
            lp  = 1'($urandom_range(0, 1));
            nt  = $urandom_range(1, 10);
            for (int i = 0; i < 8; i++) mem[i] = DATA_W'($urandom);
            doStart(len, lp);
            for (int k = 0; k < nt; k++) begin
                if (k > 0 && $urandom_range(0, 7) == 0) doStop();
                doTick($urandom_range(7, 10));
            end
            doStop();
            idle(3);
        end

`ifdef PLAYBACK_ECHO_EN
        // Echo saturation at both ends of the range
        mem[0]    = 8'd100;
        mem[3000] = 8'd100;
        mem[1]    = 8'hFE;
        mem[3001] = 8'h80;
        doStart(3002, 1'b0);
        repeat (3002) doTick(7);
        idle(4);
`endif

        idle(10);
        checkOutput("pending_samples", exp_q.size(), 0);
        checkOutput("pending_done", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
